// File: rtl/rv_dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO subsystem: access encodings,
// register offsets and STATUS bit positions.
package rv_dmem_mmio_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'h1000_0000;

  localparam logic [2:0] BC_B  = 3'b000;
  localparam logic [2:0] BC_H  = 3'b001;
  localparam logic [2:0] BC_W  = 3'b010;
  localparam logic [2:0] BC_BU = 3'b100;
  localparam logic [2:0] BC_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [4:0] OFF_GPIO_OUT    = 5'h00;
  localparam logic [4:0] OFF_GPIO_IN     = 5'h04;
  localparam logic [4:0] OFF_MTIME_LO    = 5'h08;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h0C;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h10;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h14;
  localparam logic [4:0] OFF_STATUS      = 5'h18;

  localparam int STATUS_IRQ_BIT = 0;
  localparam int STATUS_ERR_BIT = 1;

  function automatic logic bc_valid(input logic [2:0] bc);
    return (bc == BC_B) || (bc == BC_H) || (bc == BC_W) ||
           (bc == BC_BU) || (bc == BC_HU);
  endfunction

endpackage

// File: rtl/rv_dmem_mmio_mtimer.sv
// Machine timer: free-running 64-bit mtime, 64-bit mtimecmp, registered
// compare interrupt. Halves are written independently through 32-bit ports.
module rv_mtimer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wdata,
  input  logic        mtime_lo_we,
  input  logic        mtime_hi_we,
  input  logic        cmp_lo_we,
  input  logic        cmp_hi_we,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        irq
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        irq_q, irq_d;

  always_comb begin
    mtime_d = mtime_q + 64'd1;
    if (mtime_lo_we)      mtime_d = {mtime_q[63:32], wdata};
    else if (mtime_hi_we) mtime_d = {wdata, mtime_q[31:0]};
    cmp_d = cmp_q;
    if (cmp_lo_we) cmp_d[31:0]  = wdata;
    if (cmp_hi_we) cmp_d[63:32] = wdata;
    // compare uses pre-edge values so irq lags the match by one cycle
    irq_d = (mtime_q >= cmp_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q <= '0;
      cmp_q   <= '1;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      irq_q   <= irq_d;
    end
  end

  assign mtime    = mtime_q;
  assign mtimecmp = cmp_q;
  assign irq      = irq_q;

endmodule

// File: rtl/rv_dmem_mmio.sv
// MEM-stage data port: byte-lane RAM with combinational load path plus a
// small MMIO block (GPIO, machine timer, STATUS).
module rv_dmem_mmio
  import rv_dmem_mmio_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter int               DMEM_WORDS = 1024,
  parameter logic [XLEN-1:0]  MMIO_BASE  = MMIO_BASE_DEF
) (
  input  logic            i_dm_clk,
  input  logic            i_dm_rst,
  input  logic [XLEN-1:0] i_dm_a,
  input  logic [XLEN-1:0] i_dm_wd,
  input  logic            i_dm_we,
  input  logic [2:0]      i_dm_bytectrl,
  output logic [XLEN-1:0] o_dm_rd,
  input  logic [31:0]     i_dm_gpio_in,
  output logic [31:0]     o_dm_gpio_out,
  output logic            o_dm_timer_irq,
  output logic            o_dm_err
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [1:0]      size;
  logic            bc_ok, is_ram, is_mmio, misalign, fault, store_ok, mmio_we;
  logic [XLEN-1:0] mmio_off_full;
  logic [4:0]      off;
  logic [AW-1:0]   word_idx;

  always_comb begin
    size          = i_dm_bytectrl[1:0];
    bc_ok         = bc_valid(i_dm_bytectrl);
    is_ram        = (i_dm_a < MMIO_BASE);
    mmio_off_full = i_dm_a - MMIO_BASE;
    is_mmio       = !is_ram && (mmio_off_full < XLEN'(32));
    off           = mmio_off_full[4:0];
    misalign      = ((size == SZ_H) && i_dm_a[0]) ||
                    ((size == SZ_W) && (i_dm_a[1:0] != 2'b00));
    // an invalid bytectrl without a store strobe is simply an idle cycle
    fault         = (i_dm_we || bc_ok) &&
                    (!bc_ok || misalign || (!is_ram && !is_mmio) ||
                     (is_mmio && (size != SZ_W)));
    store_ok      = i_dm_we && !fault;
    mmio_we       = store_ok && is_mmio;
    word_idx      = i_dm_a[AW+1:2];
  end

  logic [3:0]      lane_we;
  logic [31:0]     wd_rep;
  logic [31:0]     ram_word;

  always_comb begin
    lane_we = 4'b0000;
    wd_rep  = i_dm_wd;
    unique case (size)
      SZ_B: begin
        wd_rep                = {4{i_dm_wd[7:0]}};
        lane_we[i_dm_a[1:0]]  = 1'b1;
      end
      SZ_H: begin
        wd_rep  = {2{i_dm_wd[15:0]}};
        lane_we = i_dm_a[1] ? 4'b1100 : 4'b0011;
      end
      default: lane_we = 4'b1111;
    endcase
    if (!(store_ok && is_ram)) lane_we = 4'b0000;
  end

  // RAM is not reset, so a store coinciding with reset still lands
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] ram_q [DMEM_WORDS];
    always_ff @(posedge i_dm_clk) begin
      if (lane_we[l]) ram_q[word_idx] <= wd_rep[8*l +: 8];
    end
    assign ram_word[8*l +: 8] = ram_q[word_idx];
  end

  logic [31:0] ram_shift, ram_rd, mmio_rd;
  logic [31:0] gpio_out_q, gpio_out_d;
  logic [31:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic        err_q, err_d;
  logic [63:0] mtime, mtimecmp;
  logic        irq;

  always_comb begin
    ram_shift = ram_word >> {i_dm_a[1:0], 3'b000};
    unique case (size)
      SZ_B:    ram_rd = {{24{ram_shift[7] & ~i_dm_bytectrl[2]}}, ram_shift[7:0]};
      SZ_H:    ram_rd = {{16{ram_shift[15] & ~i_dm_bytectrl[2]}}, ram_shift[15:0]};
      default: ram_rd = ram_word;
    endcase
  end

  always_comb begin
    mmio_rd = '0;
    unique case (off)
      OFF_GPIO_OUT:    mmio_rd = gpio_out_q;
      OFF_GPIO_IN:     mmio_rd = sync2_q;
      OFF_MTIME_LO:    mmio_rd = mtime[31:0];
      OFF_MTIME_HI:    mmio_rd = mtime[63:32];
      OFF_MTIMECMP_LO: mmio_rd = mtimecmp[31:0];
      OFF_MTIMECMP_HI: mmio_rd = mtimecmp[63:32];
      OFF_STATUS: begin
        mmio_rd[STATUS_IRQ_BIT] = irq;
        mmio_rd[STATUS_ERR_BIT] = err_q;
      end
      default:         mmio_rd = '0;
    endcase
  end

  assign o_dm_rd = (!bc_ok || fault) ? '0 : (is_ram ? ram_rd : mmio_rd);

  always_comb begin
    gpio_out_d = gpio_out_q;
    if (mmio_we && (off == OFF_GPIO_OUT)) gpio_out_d = i_dm_wd;
    sync1_d = i_dm_gpio_in;
    sync2_d = sync1_q;
    err_d   = err_q;
    if (fault) err_d = 1'b1;
    else if (mmio_we && (off == OFF_STATUS) && i_dm_wd[STATUS_ERR_BIT]) err_d = 1'b0;
  end

  always_ff @(posedge i_dm_clk) begin
    if (i_dm_rst) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      err_q      <= err_d;
    end
  end

  rv_mtimer u_mtimer (
    .clk         (i_dm_clk),
    .rst         (i_dm_rst),
    .wdata       (i_dm_wd),
    .mtime_lo_we (mmio_we && (off == OFF_MTIME_LO)),
    .mtime_hi_we (mmio_we && (off == OFF_MTIME_HI)),
    .cmp_lo_we   (mmio_we && (off == OFF_MTIMECMP_LO)),
    .cmp_hi_we   (mmio_we && (off == OFF_MTIMECMP_HI)),
    .mtime       (mtime),
    .mtimecmp    (mtimecmp),
    .irq         (irq)
  );

  assign o_dm_gpio_out  = gpio_out_q;
  assign o_dm_timer_irq = irq;
  assign o_dm_err       = err_q;

endmodule

// File: tb/tb_rv_dmem_mmio.sv
// Randomized bench for rv_dmem_mmio against a byte-array/integer model,
// with directed scenarios pinned by literal expectations.
module tb_rv_dmem_mmio;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          WORDS = 1024;
  localparam int          NB    = 4 * WORDS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0, wd = '0, gpio_in = '0;
  logic        we = 1'b0;
  logic [2:0]  bc = 3'b111;
  logic [31:0] rd, gpio_out;
  logic        irq, err;

  int checks = 0;
  int errors = 0;

  rv_dmem_mmio dut (
    .i_dm_clk       (clk),
    .i_dm_rst       (rst),
    .i_dm_a         (a),
    .i_dm_wd        (wd),
    .i_dm_we        (we),
    .i_dm_bytectrl  (bc),
    .o_dm_rd        (rd),
    .i_dm_gpio_in   (gpio_in),
    .o_dm_gpio_out  (gpio_out),
    .o_dm_timer_irq (irq),
    .o_dm_err       (err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0]  m_mem [NB];
  bit          m_known [NB];
  logic [31:0] m_gpio_out, m_s1, m_s2;
  logic [63:0] m_mtime, m_cmp;
  logic        m_irq, m_err;
  bit          model_live = 0;

  function automatic bit bc_legal(input logic [2:0] c);
    return (c == 3'd0) || (c == 3'd1) || (c == 3'd2) || (c == 3'd4) || (c == 3'd5);
  endfunction

  function automatic int nbytes(input logic [2:0] c);
    return (c[1:0] == 2'd0) ? 1 : (c[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_fault(input logic [31:0] ad, input logic [2:0] c, input logic w);
    if (!bc_legal(c)) return w;
    if ((ad % nbytes(c)) != 0) return 1;
    if (ad < BASE) return 0;
    if (ad - BASE < 32) return nbytes(c) != 4;
    return 1;
  endfunction

  function automatic int ram_byte_index(input logic [31:0] ad);
    return int'(((ad >> 2) % WORDS) * 4 + (ad % 4));
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] ad, input logic [2:0] c,
                                         output bit known);
    logic [31:0] v;
    int n, bi;
    known = 1;
    v = '0;
    if (!bc_legal(c) || m_fault(ad, c, 1'b0)) return '0;
    if (ad < BASE) begin
      n  = nbytes(c);
      bi = ram_byte_index(ad);
      for (int i = 0; i < n; i++) begin
        if (!m_known[bi + i]) known = 0;
        v = v | (32'(m_mem[bi + i]) << (8 * i));
      end
      if (!c[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!c[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      return v;
    end
    case (ad - BASE)
      32'h00:  return m_gpio_out;
      32'h04:  return m_s2;
      32'h08:  return m_mtime[31:0];
      32'h0C:  return m_mtime[63:32];
      32'h10:  return m_cmp[31:0];
      32'h14:  return m_cmp[63:32];
      32'h18:  return {30'd0, m_err, m_irq};
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit          f, st;
    logic [63:0] t_next;
    logic        i_next;
    int          bi;
    f  = m_fault(a, bc, we);
    st = we && !f;
    if (st && a < BASE) begin
      bi = ram_byte_index(a);
      for (int i = 0; i < nbytes(bc); i++) begin
        m_mem[bi + i]   = wd[8*i +: 8];
        m_known[bi + i] = 1;
      end
    end
    if (rst) begin
      m_gpio_out = '0; m_s1 = '0; m_s2 = '0;
      m_mtime = '0; m_cmp = '1; m_irq = 0; m_err = 0;
      model_live = 1;
    end else begin
      i_next = (m_mtime >= m_cmp);
      t_next = m_mtime + 64'd1;
      m_s2 = m_s1;
      m_s1 = gpio_in;
      if (st && a >= BASE) begin
        case (a - BASE)
          32'h00: m_gpio_out = wd;
          32'h08: t_next = {m_mtime[63:32], wd};
          32'h0C: t_next = {wd, m_mtime[31:0]};
          32'h10: m_cmp[31:0] = wd;
          32'h14: m_cmp[63:32] = wd;
          32'h18: if (wd[1]) m_err = 0;
          default: ;
        endcase
      end
      if (f) m_err = 1;
      m_mtime = t_next;
      m_irq   = i_next;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    bit          k;
    if (model_live) begin
      e = exp_rd(a, bc, k);
      if (k) chk("model_rd", rd, e);
      chk("model_gpio_out", gpio_out, m_gpio_out);
      chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
      chk("model_err", {31'd0, err}, {31'd0, m_err});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic [31:0] ad, input logic [31:0] d,
                       input logic w, input logic [2:0] c);
    @(posedge clk);
    #1;
    rst = r; a = ad; wd = d; we = w; bc = c;
  endtask

  task automatic put(input logic [31:0] ad, input logic [31:0] d,
                     input logic w, input logic [2:0] c);
    drive(1'b0, ad, d, w, c);
  endtask

  task automatic idle();
    put('0, '0, 1'b0, 3'b111);
  endtask

  task automatic reset_dut();
    drive(1'b1, '0, '0, 1'b0, 3'b111);
    @(posedge clk);
  endtask

  initial begin
    bit          done;
    bit          prev20;
    logic [31:0] ad, d;
    logic [2:0]  c;
    logic        w;

    reset_dut();
    put(BASE + 32'h08, '0, 1'b0, 3'b010);
    @(negedge clk);
    chk("rst_mtime_lo", rd, 32'h0);
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    chk("rst_err", {31'd0, err}, 32'h0);
    put(BASE + 32'h14, '0, 1'b0, 3'b010);
    @(negedge clk);
    chk("rst_mtimecmp_hi", rd, 32'hFFFF_FFFF);
    put(BASE + 32'h18, '0, 1'b0, 3'b010);
    @(negedge clk);
    chk("rst_status", rd, 32'h0);

    for (int i = 0; i < WORDS; i++) put(32'(i * 4), $urandom, 1'b1, 3'b010);

    // byte store and sign/zero extension
    put(32'h100, 32'h1122_3344, 1'b1, 3'b010);
    put(32'h101, 32'h0000_00A5, 1'b1, 3'b000);
    put(32'h101, '0, 1'b0, 3'b000);
    @(negedge clk);
    chk("lb_0x101", rd, 32'hFFFF_FFA5);
    put(32'h101, '0, 1'b0, 3'b100);
    @(negedge clk);
    chk("lbu_0x101", rd, 32'h0000_00A5);
    put(32'h100, '0, 1'b0, 3'b010);
    @(negedge clk);
    chk("lw_0x100_lanes", rd, 32'h1122_A544);

    // halfword loads and aliasing
    put(32'h200, 32'h1234_5678, 1'b1, 3'b010);
    put(32'h202, '0, 1'b0, 3'b001);
    @(negedge clk);
    chk("lh_0x202", rd, 32'h0000_1234);
    put(32'h200, '0, 1'b0, 3'b101);
    @(negedge clk);
    chk("lhu_0x200", rd, 32'h0000_5678);
    put(32'h200 + 4 * WORDS, '0, 1'b0, 3'b010);
    @(negedge clk);
    chk("lw_alias", rd, 32'h1234_5678);

    // misaligned store, STATUS read and W1C
    put(32'h300, 32'hCAFE_F00D, 1'b1, 3'b010);
    put(32'h301, 32'h0000_BEEF, 1'b1, 3'b001);
    put(32'h300, '0, 1'b0, 3'b010);
    @(negedge clk);
    chk("sh_misalign_ram", rd, 32'hCAFE_F00D);
    chk("sh_misalign_err", {31'd0, err}, 32'h1);
    put(BASE + 32'h18, '0, 1'b0, 3'b010);
    @(negedge clk);
    chk("status_err", rd, 32'h2);
    put(BASE + 32'h18, 32'h2, 1'b1, 3'b010);
    idle();
    @(negedge clk);
    chk("status_w1c", {31'd0, err}, 32'h0);

    // timer compare interrupt
    reset_dut();
    put(BASE + 32'h14, 32'h0, 1'b1, 3'b010);
    put(BASE + 32'h10, 32'd20, 1'b1, 3'b010);
    done = 0;
    prev20 = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      put(BASE + 32'h08, '0, 1'b0, 3'b010);
      @(negedge clk);
      if (prev20) begin
        chk("irq_rise", {31'd0, irq}, 32'h1);
        done = 1;
      end else if (rd == 32'd20) begin
        chk("irq_low_at_match", {31'd0, irq}, 32'h0);
        prev20 = 1;
      end
    end
    chk("irq_rise_seen", {31'd0, done}, 32'h1);
    put(BASE + 32'h10, 32'hFFFF_FFFF, 1'b1, 3'b010);
    idle();
    @(negedge clk);
    chk("irq_hold", {31'd0, irq}, 32'h1);
    idle();
    @(negedge clk);
    chk("irq_fall", {31'd0, irq}, 32'h0);

    // mtime carry into the high half
    put(BASE + 32'h08, 32'hFFFF_FFFE, 1'b1, 3'b010);
    idle();
    idle();
    put(BASE + 32'h0C, '0, 1'b0, 3'b010);
    @(negedge clk);
    chk("mtime_hi_carry", rd, 32'h1);
    put(BASE + 32'h08, '0, 1'b0, 3'b010);
    @(negedge clk);
    chk("mtime_lo_wrap", rd, 32'h1);

    // GPIO input synchronizer latency
    gpio_in = '0;
    idle(); idle(); idle();
    put(BASE + 32'h04, '0, 1'b0, 3'b010);
    gpio_in = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("gpio_in_edge0", rd, 32'h0);
    put(BASE + 32'h04, '0, 1'b0, 3'b010);
    @(negedge clk);
    chk("gpio_in_edge1", rd, 32'h0);
    put(BASE + 32'h04, '0, 1'b0, 3'b010);
    @(negedge clk);
    chk("gpio_in_edge2", rd, 32'hDEAD_BEEF);

    // sub-word store to MMIO is rejected
    put(BASE, 32'h5A5A_0000, 1'b1, 3'b010);
    put(BASE, 32'h0000_00FF, 1'b1, 3'b000);
    idle();
    @(negedge clk);
    chk("sb_mmio_err", {31'd0, err}, 32'h1);
    chk("sb_mmio_gpio", gpio_out, 32'h5A5A_0000);

    // random traffic, checked by the model each cycle
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: ad = $urandom_range(0, 4095) | ($urandom_range(0, 3) << 12);
        6, 7, 8: ad = BASE + 4 * $urandom_range(0, 7) +
                      (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        default: ad = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: c = 3'd0;
        1: c = 3'd1;
        2: c = 3'd2;
        3: c = 3'd4;
        4: c = 3'd5;
        5: c = 3'd2;
        default: c = 3'($urandom_range(0, 7));
      endcase
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      drive(($urandom_range(0, 199) == 0), ad, d, w, c);
      if ($urandom_range(0, 3) == 0) gpio_in = $urandom;
    end

    idle();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
